serial_subtractor: RTL and testbench



---
 rtl/serial_subtractor.sv | 97 +++++++++
 tb/tb_serial_subtractor.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: s = a - b - c_in, one bit per clock, LSB first.
// One full-subtractor cell plus a borrow flip-flop, framed by a start/busy/done handshake.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_s;
  logic             r_borrow;
  logic [CW-1:0]    r_cnt;
  logic             r_c_out;
  logic             r_zero;

  logic             w_d;
  logic             w_borrow;
  logic [WIDTH-1:0] w_s_next;
  logic             w_last;

  always_comb begin
    w_d      = r_a[0] ^ r_b[0] ^ r_borrow;
    w_borrow = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_borrow);
    w_s_next = {w_d, r_s[WIDTH-1:1]};
    w_last   = (r_cnt == LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_s      <= '0;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
      r_c_out  <= 1'b0;
      r_zero   <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_a      <= a;
            r_b      <= b;
            r_borrow <= c_in;
            r_cnt    <= '0;
            r_s      <= '0;
            r_state  <= SHIFT;
          end else begin
            r_state  <= IDLE;
          end
        end
        SHIFT: begin
          r_s      <= w_s_next;
          r_a      <= r_a >> 1;
          r_b      <= r_b >> 1;
          r_borrow <= w_borrow;
          r_cnt    <= r_cnt + ONE;
          // Last bit: publish the final borrow and zero flag alongside the completed s.
          if (w_last) begin
            r_c_out <= w_borrow;
            r_zero  <= (w_s_next == '0);
            r_state <= DONE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign s     = r_s;
  assign c_out = r_c_out;
  assign zero  = r_zero;
  assign busy  = (r_state == SHIFT);
  assign done  = (r_state == DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: expected results are queued at launch
// and popped when done is observed.
module tb_serial_subtractor;

  localparam int W = 4;

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         z;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c_in;
  logic [W-1:0] s;
  logic         c_out;
  logic         zero;
  logic         busy;
  logic         done;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t q[$];

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .c_in  (c_in),
    .s     (s),
    .c_out (c_out),
    .zero  (zero),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
    logic [W:0] d;
    exp_t e;
    d   = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, ci};
    e.s = d[W-1:0];
    e.c = d[W];
    e.z = (d[W-1:0] == '0);
    return e;
  endfunction

  // Called at a negedge; returns the number of negedges until done is seen.
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("done_timeout", {31'd0, done}, 32'd1);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    chk({tag, "_queue"}, (q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
    if (q.size() > 0) begin
      e = q.pop_front();
      chk({tag, "_s"},    {28'd0, s},     {28'd0, e.s});
      chk({tag, "_cout"}, {31'd0, c_out}, {31'd0, e.c});
      chk({tag, "_zero"}, {31'd0, zero},  {31'd0, e.z});
      chk({tag, "_busy"}, {31'd0, busy},  32'd0);
    end
  endtask

  task automatic launch(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
    a     = x;
    b     = y;
    c_in  = ci;
    start = 1'b1;
    q.push_back(model(x, y, ci));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                    input logic ci);
    int cyc;
    launch(x, y, ci);
    chk({tag, "_busy_start"}, {31'd0, busy}, 32'd1);
    wait_done(cyc);
    chk({tag, "_latency"}, cyc, W);
    pop_check(tag);
    @(negedge clk);
    chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int cyc;
    int n_done;
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    c_in  = 1'b0;

    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_s",    {28'd0, s},     32'd0);
    chk("rst_cout", {31'd0, c_out}, 32'd0);
    chk("rst_zero", {31'd0, zero},  32'd0);
    chk("rst_busy", {31'd0, busy},  32'd0);
    chk("rst_done", {31'd0, done},  32'd0);

    op("a7b3",   4'd7,  4'd3,  1'b0);
    op("a3b7",   4'd3,  4'd7,  1'b0);
    op("a0b0c1", 4'd0,  4'd0,  1'b1);
    op("a15b15", 4'd15, 4'd15, 1'b0);

    // start re-raised mid-operation must be ignored
    launch(4'd9, 4'd2, 1'b0);
    @(negedge clk);
    start = 1'b1;
    a     = 4'd1;
    b     = 4'd1;
    @(negedge clk);
    start = 1'b0;
    a     = 4'd0;
    b     = 4'd0;
    wait_done(cyc);
    chk("ign_latency", cyc, 2);
    pop_check("ign");
    n_done = 0;
    repeat (6) begin
      @(negedge clk);
      if (done === 1'b1) n_done++;
    end
    chk("ign_single_done", n_done, 0);

    // reset aborts an operation in flight
    launch(4'd5, 4'd1, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    chk("abort_busy", {31'd0, busy},  32'd0);
    chk("abort_done", {31'd0, done},  32'd0);
    chk("abort_s",    {28'd0, s},     32'd0);
    chk("abort_cout", {31'd0, c_out}, 32'd0);
    chk("abort_zero", {31'd0, zero},  32'd0);
    n_done = 0;
    repeat (6) begin
      @(negedge clk);
      if (done === 1'b1) n_done++;
    end
    chk("abort_no_done", n_done, 0);

    // back-to-back with start held high
    a     = 4'd10;
    b     = 4'd4;
    c_in  = 1'b0;
    start = 1'b1;
    q.push_back(model(4'd10, 4'd4, 1'b0));
    @(negedge clk);
    wait_done(cyc);
    chk("b2b_first_latency", cyc, W);
    pop_check("b2b1");
    a = 4'd4;
    b = 4'd10;
    q.push_back(model(4'd4, 4'd10, 1'b0));
    @(negedge clk);
    start = 1'b0;
    chk("b2b_busy_resume", {31'd0, busy}, 32'd1);
    wait_done(cyc);
    chk("b2b_spacing", cyc + 1, W + 1);
    pop_check("b2b2");
    @(negedge clk);

    // exhaustive sweep
    for (int ci = 0; ci < 2; ci++) begin
      for (int x = 0; x < 16; x++) begin
        for (int y = 0; y < 16; y++) begin
          launch(W'(x), W'(y), ci[0]);
          wait_done(cyc);
          pop_check("sweep");
          @(negedge clk);
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
